// File: rtl/mac_dot_engine_if.sv
// Operand stream, result stream and status signals of mac_dot_engine.
// master = operand streamer / result collector side, slave = the engine.
interface mac_dot_engine_if #(
    parameter int N     = 8,
    parameter int ACC_W = 32,
    parameter int LEN_W = 8
);
    logic [N-1:0]     x;
    logic [N-1:0]     w;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [ACC_W-1:0] out;
    logic [LEN_W-1:0] out_count;
    logic             out_ovf;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    modport master (
        output x, w, in_valid, in_last, out_ready,
        input  in_ready, out, out_count, out_ovf, out_valid, busy
    );

    modport slave (
        input  x, w, in_valid, in_last, out_ready,
        output in_ready, out, out_count, out_ovf, out_valid, busy
    );
endinterface

// File: rtl/mac_dot_engine.sv
// Two-stage pipelined dot-product engine: product register, then accumulate/FSM/result.
// Optional clamping on accumulator overflow when MAC_SATURATE_EN is defined.
module mac_dot_engine #(
    parameter int N      = 8,
    parameter int ACC_W  = 32,
    parameter int LEN_W  = 8,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    mac_dot_engine_if.slave   bus,
    output logic              state_dbg
);
    // Handshakes: a beat moves when in_valid & in_ready at a rising edge; a result
    // is taken when out_valid & out_ready, and out* hold steady until then.
    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t           state;
    logic [2*N-1:0]   p;
    logic             p_valid;
    logic             p_last;
    logic [ACC_W-1:0] acc;
    logic [LEN_W-1:0] cnt;
    logic             ovf;

    logic [2*N-1:0]   prod;
    logic [ACC_W-1:0] p_ext;
    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] raw;
    logic             add_ovf;
    logic [ACC_W-1:0] acc_next;
    logic [LEN_W-1:0] cnt_next;
    logic             ovf_next;
    logic             stall2;
    logic             fire2;
    logic             accept;

    always_comb begin
        prod  = '0;
        p_ext = '0;
        if (SIGNED != 0) begin
            prod  = $signed({{N{bus.x[N-1]}}, bus.x}) * $signed({{N{bus.w[N-1]}}, bus.w});
            p_ext = ACC_W'($signed(p));
        end else begin
            prod  = {{N{1'b0}}, bus.x} * {{N{1'b0}}, bus.w};
            p_ext = ACC_W'(p);
        end
    end

    // The first beat of a frame adds onto zero, so it can never overflow.
    assign base    = (state == ACCUM) ? acc : '0;
    assign sum_ext = {1'b0, base} + {1'b0, p_ext};
    assign raw     = sum_ext[ACC_W-1:0];

    always_comb begin
        add_ovf = 1'b0;
        if (SIGNED != 0)
            add_ovf = (base[ACC_W-1] == p_ext[ACC_W-1]) && (raw[ACC_W-1] != base[ACC_W-1]);
        else
            add_ovf = sum_ext[ACC_W];
    end

`ifdef MAC_SATURATE_EN
    always_comb begin
        acc_next = raw;
        if (add_ovf) begin
            if (SIGNED != 0)
                acc_next = base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            else
                acc_next = '1;
        end
    end
`else
    assign acc_next = raw;
`endif

    assign cnt_next = (state == IDLE) ? LEN_W'(1) : ((&cnt) ? cnt : cnt + 1'b1);
    assign ovf_next = ((state == ACCUM) & ovf) | add_ovf;

    // Only a finished frame waits on the output register; partial sums keep flowing.
    assign stall2 = p_valid & p_last & bus.out_valid & ~bus.out_ready;
    assign fire2  = p_valid & ~stall2;
    assign accept = bus.in_valid & bus.in_ready;

    assign bus.in_ready = rst & ~stall2;
    assign bus.busy     = (state == ACCUM) | p_valid;
    assign state_dbg    = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            p             <= '0;
            p_valid       <= 1'b0;
            p_last        <= 1'b0;
            acc           <= '0;
            cnt           <= '0;
            ovf           <= 1'b0;
            bus.out       <= '0;
            bus.out_count <= '0;
            bus.out_ovf   <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            if (accept) begin
                p       <= prod;
                p_valid <= 1'b1;
                p_last  <= bus.in_last;
            end else if (fire2) begin
                p_valid <= 1'b0;
            end

            if (bus.out_valid && bus.out_ready)
                bus.out_valid <= 1'b0;

            if (fire2) begin
                if (p_last) begin
                    bus.out       <= acc_next;
                    bus.out_count <= cnt_next;
                    bus.out_ovf   <= ovf_next;
                    bus.out_valid <= 1'b1;
                    acc           <= '0;
                    cnt           <= '0;
                    ovf           <= 1'b0;
                    state         <= IDLE;
                end else begin
                    acc   <= acc_next;
                    cnt   <= cnt_next;
                    ovf   <= ovf_next;
                    state <= ACCUM;
                end
            end
        end
    end
endmodule

// File: tb/tb_mac_dot_engine.sv
// Directed bench for mac_dot_engine: three instances (unsigned/32, signed/32, unsigned/16)
// checked against a frame-level arithmetic model plus hand-computed literals.
module tb_mac_dot_engine;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    mac_dot_engine_if #(.N(8), .ACC_W(32), .LEN_W(8)) if_u ();
    mac_dot_engine_if #(.N(8), .ACC_W(32), .LEN_W(8)) if_s ();
    mac_dot_engine_if #(.N(8), .ACC_W(16), .LEN_W(8)) if_n ();
    logic st_u, st_s, st_n;

    mac_dot_engine #(.N(8), .ACC_W(32), .LEN_W(8), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .bus(if_u.slave), .state_dbg(st_u));
    mac_dot_engine #(.N(8), .ACC_W(32), .LEN_W(8), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .bus(if_s.slave), .state_dbg(st_s));
    mac_dot_engine #(.N(8), .ACC_W(16), .LEN_W(8), .SIGNED(0)) dut_n (
        .clk(clk), .rst(rst), .bus(if_n.slave), .state_dbg(st_n));

    logic [7:0]  drv_x [3];
    logic [7:0]  drv_w [3];
    logic        drv_valid [3];
    logic        drv_last [3];
    logic        drv_ordy [3];
    logic [31:0] got_out [3];
    logic [7:0]  got_cnt [3];
    logic        got_ovf [3];
    logic        got_valid [3];
    logic        rdy [3];
    logic        bsy [3];

    assign if_u.x = drv_x[0];  assign if_u.w = drv_w[0];  assign if_u.in_valid = drv_valid[0];
    assign if_u.in_last = drv_last[0];  assign if_u.out_ready = drv_ordy[0];
    assign if_s.x = drv_x[1];  assign if_s.w = drv_w[1];  assign if_s.in_valid = drv_valid[1];
    assign if_s.in_last = drv_last[1];  assign if_s.out_ready = drv_ordy[1];
    assign if_n.x = drv_x[2];  assign if_n.w = drv_w[2];  assign if_n.in_valid = drv_valid[2];
    assign if_n.in_last = drv_last[2];  assign if_n.out_ready = drv_ordy[2];

    assign got_out[0] = if_u.out;  assign got_cnt[0] = if_u.out_count;  assign got_ovf[0] = if_u.out_ovf;
    assign got_out[1] = if_s.out;  assign got_cnt[1] = if_s.out_count;  assign got_ovf[1] = if_s.out_ovf;
    assign got_out[2] = 32'(if_n.out);  assign got_cnt[2] = if_n.out_count;  assign got_ovf[2] = if_n.out_ovf;
    assign got_valid[0] = if_u.out_valid;  assign rdy[0] = if_u.in_ready;  assign bsy[0] = if_u.busy;
    assign got_valid[1] = if_s.out_valid;  assign rdy[1] = if_s.in_ready;  assign bsy[1] = if_s.busy;
    assign got_valid[2] = if_n.out_valid;  assign rdy[2] = if_n.in_ready;  assign bsy[2] = if_n.busy;

    // Model state: beats of the open frame per instance, expected and observed results.
    int          is_signed [3] = '{0, 1, 0};
    int          accw [3]      = '{32, 32, 16};
    logic [7:0]  cur_x [3][$];
    logic [7:0]  cur_w [3][$];
    logic [40:0] exp_q [3][$];
    logic [40:0] got_log [3][$];

    function automatic logic [40:0] model_frame(input int id);
        longint sum = 0;
        longint prod, hi, lo, span;
        bit     fovf = 1'b0;
        logic [7:0]  xb, wb, c;
        logic [31:0] sbits;
        span = longint'(1) << accw[id];
        if (is_signed[id] != 0) begin
            hi = span / 2 - 1;
            lo = -(span / 2);
        end else begin
            hi = span - 1;
            lo = 0;
        end
        for (int i = 0; i < cur_x[id].size(); i++) begin
            xb = cur_x[id][i];
            wb = cur_w[id][i];
            if (is_signed[id] != 0) prod = longint'($signed(xb)) * longint'($signed(wb));
            else                    prod = longint'(xb) * longint'(wb);
            sum = sum + prod;
            if (sum > hi || sum < lo) begin
                fovf = 1'b1;
`ifdef MAC_SATURATE_EN
                sum = (sum > hi) ? hi : lo;
`else
                sum = sum & (span - 1);
                if (sum > hi) sum = sum - span;
`endif
            end
        end
        c = (cur_x[id].size() > 255) ? 8'd255 : 8'(cur_x[id].size());
        sbits = 32'(sum & (span - 1));
        return {fovf, c, sbits};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic send(input int id, input logic [7:0] xv, input logic [7:0] wv,
                        input logic last, output int waits);
        drv_x[id] = xv;  drv_w[id] = wv;  drv_last[id] = last;  drv_valid[id] = 1'b1;
        waits = 0;
        while (1) begin
            @(negedge clk);
            if (rdy[id]) begin
                cur_x[id].push_back(xv);
                cur_w[id].push_back(wv);
                if (last) begin
                    exp_q[id].push_back(model_frame(id));
                    cur_x[id].delete();
                    cur_w[id].delete();
                end
                @(posedge clk);
                #1;
                break;
            end
            waits++;
            if (waits > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout dut%0d: in_ready stayed 0 for %0d cycles, expected 1", id, waits);
                @(posedge clk);
                #1;
                break;
            end
        end
        drv_valid[id] = 1'b0;
        drv_last[id]  = 1'b0;
    endtask

    task automatic expect_lit(input string name, input int id, input logic [31:0] sv,
                              input logic [7:0] cv, input logic ov);
        int k = 0;
        logic [40:0] r;
        while (got_log[id].size() == 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (got_log[id].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no result after %0d cycles, expected out=0x%0h", name, k, sv);
        end else begin
            r = got_log[id].pop_front();
            chk({name, "_out"}, r[31:0], sv);
            chk({name, "_count"}, 32'(r[39:32]), 32'(cv));
            chk({name, "_ovf"}, 32'(r[40]), 32'(ov));
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted result must match the model's next expected frame.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                if (got_valid[i] && drv_ordy[i]) begin
                    checks++;
                    if (exp_q[i].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_result dut%0d: got out=0x%0h, expected no result", i, got_out[i]);
                    end else if ({got_ovf[i], got_cnt[i], got_out[i]} !== exp_q[i][0]) begin
                        errors++;
                        $display("FAIL result dut%0d: got ovf=%0d cnt=%0d out=0x%0h expected ovf=%0d cnt=%0d out=0x%0h",
                                 i, got_ovf[i], got_cnt[i], got_out[i],
                                 exp_q[i][0][40], exp_q[i][0][39:32], exp_q[i][0][31:0]);
                        void'(exp_q[i].pop_front());
                    end else begin
                        void'(exp_q[i].pop_front());
                    end
                    got_log[i].push_back({got_ovf[i], got_cnt[i], got_out[i]});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wt;
        int total;
        for (int i = 0; i < 3; i++) begin
            drv_x[i] = '0;  drv_w[i] = '0;  drv_valid[i] = 1'b0;
            drv_last[i] = 1'b0;  drv_ordy[i] = 1'b1;
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(rdy[0]), 0);
        chk("reset_busy", 32'(bsy[0]), 0);
        chk("reset_out_valid", 32'(got_valid[0]), 0);
        chk("reset_out", got_out[0], 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", 32'(rdy[0]), 1);

        // Basic unsigned frame and result latency.
        send(0, 8'd5, 8'd2, 1'b0, wt);
        send(0, 8'd3, 8'd4, 1'b0, wt);
        send(0, 8'd7, 8'd9, 1'b0, wt);
        send(0, 8'd8, 8'd6, 1'b1, wt);
        @(negedge clk);
        chk("latency_t", 32'(got_valid[0]), 0);
        @(negedge clk);
        chk("latency_t1", 32'(got_valid[0]), 1);
        @(negedge clk);
        chk("valid_one_cycle", 32'(got_valid[0]), 0);
        expect_lit("frame4", 0, 32'd133, 8'd4, 1'b0);

        // Single-beat frame back-to-back with a two-beat frame.
        total = 0;
        send(0, 8'd3, 8'd4, 1'b1, wt);  total += wt;
        send(0, 8'd1, 8'd1, 1'b0, wt);  total += wt;
        send(0, 8'd2, 8'd2, 1'b1, wt);  total += wt;
        chk("b2b_no_wait", 32'(total), 0);
        expect_lit("single", 0, 32'd12, 8'd1, 1'b0);
        expect_lit("pair", 0, 32'd5, 8'd2, 1'b0);

        // Output back-pressure stalls only the pending last product.
        drv_ordy[0] = 1'b0;
        send(0, 8'd2, 8'd5, 1'b1, wt);
        send(0, 8'd4, 8'd5, 1'b1, wt);
        @(negedge clk);
        chk("stall_in_ready", 32'(rdy[0]), 0);
        chk("stall_out", got_out[0], 32'd10);
        chk("stall_valid", 32'(got_valid[0]), 1);
        repeat (2) @(negedge clk);
        chk("stall_hold_out", got_out[0], 32'd10);
        chk("stall_busy", 32'(bsy[0]), 1);
        @(posedge clk);
        #1;
        drv_ordy[0] = 1'b1;
        expect_lit("stall_a", 0, 32'd10, 8'd1, 1'b0);
        expect_lit("stall_b", 0, 32'd20, 8'd1, 1'b0);

        // Signed instance.
        send(1, 8'hFD, 8'h04, 1'b1, wt);
        expect_lit("signed_neg", 1, 32'hFFFF_FFF4, 8'd1, 1'b0);
        send(1, 8'h80, 8'h80, 1'b0, wt);
        send(1, 8'hFF, 8'h02, 1'b1, wt);
        expect_lit("signed_mix", 1, 32'd16382, 8'd2, 1'b0);

        // 16-bit accumulator overflow.
        send(2, 8'd255, 8'd255, 1'b0, wt);
        send(2, 8'd255, 8'd255, 1'b1, wt);
`ifdef MAC_SATURATE_EN
        expect_lit("acc16_ovf", 2, 32'd65535, 8'd1 + 8'd1, 1'b1);
`else
        expect_lit("acc16_ovf", 2, 32'd64514, 8'd1 + 8'd1, 1'b1);
`endif

        // Beat counter saturates at 255 while the sum keeps counting.
        for (int i = 0; i < 256; i++) send(0, 8'd1, 8'd1, (i == 255), wt);
        expect_lit("cnt_sat", 0, 32'd256, 8'd255, 1'b0);

        // Reset mid-frame discards the partial sum.
        send(0, 8'd1, 8'd1, 1'b0, wt);
        send(0, 8'd2, 8'd2, 1'b0, wt);
        rst = 1'b0;
        #1;
        chk("midreset_busy", 32'(bsy[0]), 0);
        chk("midreset_valid", 32'(got_valid[0]), 0);
        chk("midreset_out", got_out[0], 0);
        chk("midreset_count", 32'(got_cnt[0]), 0);
        chk("midreset_state", 32'(st_u), 0);
        for (int i = 0; i < 3; i++) begin
            cur_x[i].delete();
            cur_w[i].delete();
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        send(0, 8'd2, 8'd3, 1'b1, wt);
        expect_lit("after_reset", 0, 32'd6, 8'd1, 1'b0);

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("drain_exp_dut%0d", i), 32'(exp_q[i].size()), 0);
            chk($sformatf("drain_log_dut%0d", i), 32'(got_log[i].size()), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
